pc_sequencer: RTL and testbench

//  Parametrised fetch-address generator; successor to the single-mode PC register.

---
 rtl/pc_pkg.sv | 25 ++
 rtl/pc_ras.sv | 50 +++++
 rtl/pc_sequencer.sv | 120 ++++++++++++
 tb/tb_pc_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types for the fetch-address generator: PC select codes, FSM states
// and the instruction alignment mask.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_SEQ    = 3'd0,
    PC_BRANCH = 3'd1,
    PC_JALR   = 3'd2,
    PC_TRAP   = 3'd3,
    PC_RET    = 3'd4
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic is_redirect(input logic [2:0] sel);
    return (sel >= 3'd1) && (sel <= 3'd4);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full;
// pop+push in one cycle replaces the top entry in place.
module pc_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            areset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [XLEN-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW:0]     r_count;
  logic [PW-1:0]   w_top_idx;
  logic            w_do_pop;

  assign w_top_idx = r_wptr - 1'b1;
  assign w_do_pop  = pop && (r_count != '0);
  assign top       = r_mem[w_top_idx];
  assign empty     = (r_count == '0);

  // NOTE: storage has no reset; r_count gates every read, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      if (w_do_pop) r_mem[w_top_idx] <= push_data;
      else          r_mem[r_wptr]    <= push_data;
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_wptr  <= '0;
      r_count <= '0;
    end else if (push && !w_do_pop) begin
      r_wptr <= r_wptr + 1'b1;
      if (r_count != (PW+1)'(DEPTH)) r_count <= r_count + 1'b1;
    end else if (w_do_pop && !push) begin
      r_wptr  <= w_top_idx;
      r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address generator with valid/ready I-mem request and redirect flush.
// Define PC_RAS_EN to add a return-address stack that supplies RET targets.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
  parameter int              INC          = 4,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            areset,
  input  logic            load,
  input  logic [2:0]      pc_sel,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] rs1,
  input  logic            ras_push,
  output logic            imem_valid,
  input  logic            imem_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus_inc,
  output logic            flush,
  output logic            misaligned
);

  state_e          r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic            r_misaligned, w_misaligned_nxt;

  logic [XLEN-1:0] w_pc_plus_inc, w_branch_tgt, w_jalr_tgt, w_ret_tgt, w_target;
  logic            w_check_align, w_target_misaligned, w_redirect;

  assign w_pc_plus_inc = r_pc + XLEN'(INC);
  assign w_branch_tgt  = r_pc + imm_ext;
  assign w_jalr_tgt    = (rs1 + imm_ext) & ~XLEN'(1);
  assign w_redirect    = (r_state == ST_RUN) && load && is_redirect(pc_sel);

`ifdef PC_RAS_EN
  logic [XLEN-1:0] w_ras_top;
  logic            w_ras_empty;

  pc_ras #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .areset    (areset),
    .push      (w_redirect && ras_push),
    .pop       (w_redirect && (pc_sel == PC_RET)),
    .push_data (w_pc_plus_inc),
    .top       (w_ras_top),
    .empty     (w_ras_empty)
  );

  assign w_ret_tgt = w_ras_empty ? w_jalr_tgt : w_ras_top;
`else
  logic w_unused_ras_push;
  assign w_unused_ras_push = ras_push;
  assign w_ret_tgt         = w_jalr_tgt;
`endif

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    w_target      = w_branch_tgt;
    w_check_align = 1'b1;
    case (pc_sel_e'(pc_sel))
      PC_JALR: w_target = w_jalr_tgt;
      PC_RET:  w_target = w_ret_tgt;
      PC_TRAP: begin
        w_target      = TRAP_VECTOR;
        w_check_align = 1'b0;
      end
      default: ;
    endcase
    w_target_misaligned = w_check_align && ((w_target[1:0] & ALIGN_MASK) != 2'b00);
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_misaligned_nxt = 1'b0;
    case (r_state)
      ST_BOOT:     w_state_nxt = ST_RUN;
      ST_REDIRECT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_redirect) begin
          w_state_nxt = ST_REDIRECT;
          if (w_target_misaligned) begin
            w_pc_nxt         = TRAP_VECTOR;
            w_misaligned_nxt = 1'b1;
          end else begin
            w_pc_nxt = w_target;
          end
        end else if (load && imem_ready) begin
          w_pc_nxt = w_pc_plus_inc;
        end
      end
      default:     w_state_nxt = ST_BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_state      <= ST_BOOT;
      r_pc         <= RESET_VECTOR;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_misaligned <= w_misaligned_nxt;
    end
  end

  // Flush is decoded from state so an async reset drops it immediately.
  assign imem_valid  = (r_state == ST_RUN);
  assign flush       = (r_state == ST_REDIRECT);
  assign misaligned  = r_misaligned;
  assign pc          = r_pc;
  assign pc_plus_inc = w_pc_plus_inc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; the RAS section runs only when PC_RAS_EN is defined.
module tb_pc_sequencer;

  logic        clk;
  logic        areset;
  logic        load;
  logic [2:0]  pc_sel;
  logic [31:0] imm_ext;
  logic [31:0] rs1;
  logic        ras_push;
  logic        imem_valid;
  logic        imem_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus_inc;
  logic        flush;
  logic        misaligned;

  int n_vec = 0;
  int n_err = 0;

  pc_sequencer dut (
    .clk         (clk),
    .areset      (areset),
    .load        (load),
    .pc_sel      (pc_sel),
    .imm_ext     (imm_ext),
    .rs1         (rs1),
    .ras_push    (ras_push),
    .imem_valid  (imem_valid),
    .imem_ready  (imem_ready),
    .pc          (pc),
    .pc_plus_inc (pc_plus_inc),
    .flush       (flush),
    .misaligned  (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    areset     = 1'b0;
    load       = 1'b0;
    pc_sel     = 3'd0;
    imm_ext    = '0;
    rs1        = '0;
    ras_push   = 1'b0;
    imem_ready = 1'b0;
    #12;
    check("rst_pc", pc, 32'h0);
    check("rst_valid", 32'(imem_valid), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_mis", 32'(misaligned), 32'd0);
    areset = 1'b1;

    tick();
    check("boot_valid", 32'(imem_valid), 32'd1);
    check("boot_pc", pc, 32'h0);
    check("boot_link", pc_plus_inc, 32'h4);

    load = 1'b1; pc_sel = 3'd0; imem_ready = 1'b1;
    tick(); tick();
    check("seq_pc8", pc, 32'h8);

    imem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_pc", pc, 32'h8);
      check("stall_flush", 32'(flush), 32'd0);
    end
    imem_ready = 1'b1;
    tick();
    check("seq_pcC", pc, 32'hC);
    tick();
    check("seq_pc10", pc, 32'h10);

    pc_sel = 3'd1; imm_ext = 32'hFFFF_FFF8; imem_ready = 1'b0;
    tick();
    check("br_pc", pc, 32'h8);
    check("br_flush", 32'(flush), 32'd1);
    check("br_valid", 32'(imem_valid), 32'd0);
    check("br_mis", 32'(misaligned), 32'd0);
    load = 1'b0;
    tick();
    check("br_flush_end", 32'(flush), 32'd0);
    check("br_valid_back", 32'(imem_valid), 32'd1);
    check("br_pc_hold", pc, 32'h8);

    load = 1'b1; pc_sel = 3'd2; rs1 = 32'h203; imm_ext = 32'h0;
    tick();
    check("jalr_mis_pc", pc, 32'h100);
    check("jalr_mis", 32'(misaligned), 32'd1);
    check("jalr_mis_flush", 32'(flush), 32'd1);
    load = 1'b0;
    tick();
    check("jalr_mis_end", 32'(misaligned), 32'd0);
    check("jalr_flush_end", 32'(flush), 32'd0);

    load = 1'b1; pc_sel = 3'd2; rs1 = 32'h201; imm_ext = 32'h0;
    tick();
    check("jalr_bit0_pc", pc, 32'h200);
    check("jalr_bit0_mis", 32'(misaligned), 32'd0);
    rs1 = 32'h400;
    tick();
    check("redir_load_ign", pc, 32'h200);
    check("redir_to_run", 32'(flush), 32'd0);
    load = 1'b0;

    load = 1'b1; pc_sel = 3'd4; rs1 = 32'h301; imm_ext = 32'h3;
    tick();
    check("ret_jalr_pc", pc, 32'h304);
    check("ret_flush", 32'(flush), 32'd1);
    load = 1'b0;
    tick();

    load = 1'b1; pc_sel = 3'd3;
    tick();
    check("trap_pc", pc, 32'h100);
    check("trap_mis", 32'(misaligned), 32'd0);
    load = 1'b0;
    tick();

    load = 1'b1; pc_sel = 3'd7; imem_ready = 1'b1;
    tick();
    check("sel7_seq", pc, 32'h104);
    check("sel7_flush", 32'(flush), 32'd0);
    load = 1'b0;

    load = 1'b1; pc_sel = 3'd1; imm_ext = 32'h2;
    tick();
    check("br_mis_pc", pc, 32'h100);
    check("br_mis", 32'(misaligned), 32'd1);
    load = 1'b0;
    tick();

    load = 1'b1; pc_sel = 3'd1; imm_ext = 32'hFFFF_FEFC;
    tick();
    check("wrap_setup", pc, 32'hFFFF_FFFC);
    check("wrap_link", pc_plus_inc, 32'h0);
    load = 1'b0;
    tick();
    load = 1'b1; pc_sel = 3'd0; imem_ready = 1'b1;
    tick();
    check("wrap_pc", pc, 32'h0);
    load = 1'b0;

    load = 1'b1; pc_sel = 3'd1; imm_ext = 32'h55;
    tick();
    check("rst_mid_pre", 32'(flush), 32'd1);
    load = 1'b0;
    #2 areset = 1'b0;
    #1;
    check("rst_mid_pc", pc, 32'h0);
    check("rst_mid_flush", 32'(flush), 32'd0);
    check("rst_mid_mis", 32'(misaligned), 32'd0);
    check("rst_mid_valid", 32'(imem_valid), 32'd0);
    @(negedge clk);
    areset = 1'b1;
    tick();
    check("rerun_valid", 32'(imem_valid), 32'd1);

`ifdef PC_RAS_EN
    for (int i = 0; i < 5; i++) begin
      load = 1'b1; pc_sel = 3'd1; imm_ext = 32'h100; ras_push = 1'b1;
      tick();
      check("ras_push_pc", pc, 32'((i + 1) * 32'h100));
      load = 1'b0; ras_push = 1'b0;
      tick();
    end
    rs1 = 32'h800; imm_ext = 32'h0;
    for (int i = 0; i < 5; i++) begin
      load = 1'b1; pc_sel = 3'd4;
      tick();
      check("ras_ret_pc", pc, (i < 4) ? 32'(32'h404 - i * 32'h100) : 32'h800);
      load = 1'b0;
      tick();
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
